// File: rtl/gshare_branch_predictor_pkg.sv
// Shared widths, reset constants and bus/entry layouts for the gshare predictor.
// Consumers that unpack fetch/AGEX buses or BTB entries import this package.
package gshare_branch_predictor_pkg;

  localparam int BHR_BITS     = 8;
  localparam int PHT_ENTRIES  = 256;
  localparam int BTB_ENTRIES  = 16;
  localparam int BTB_IDX_BITS = 4;
  localparam int BTB_TAG_BITS = 26;

  localparam logic [1:0] PHT_INIT = 2'b01;

  localparam int FROM_FE_TO_PREDICTOR_WIDTH   = 32;
  localparam int FROM_PREDICTOR_TO_FE_WIDTH   = 55;
  localparam int FROM_AGEX_TO_PREDICTOR_WIDTH = 75;

  // BTB entry: valid, cond, tag = PC[31:6], target (60 bits)
  typedef struct packed {
    logic                    valid;
    logic                    cond;
    logic [BTB_TAG_BITS-1:0] tag;
    logic [31:0]             target;
  } btb_entry_t;

  localparam int BTB_ENTRY_WIDTH = $bits(btb_entry_t);

  typedef struct packed {
    logic                upd_valid;
    logic                upd_is_cond;
    logic                upd_taken;
    logic [31:0]         upd_pc;
    logic [31:0]         upd_target;
    logic [BHR_BITS-1:0] upd_pht_index;
  } agex_upd_t;

  typedef struct packed {
    logic                    taken;
    logic [31:0]             target_addr;
    logic [BHR_BITS-1:0]     bhr;
    logic [BHR_BITS-1:0]     pht_index;
    logic [1:0]              pht_entry;
    logic [BTB_IDX_BITS-1:0] btb_index;
  } fe_pred_t;

  function automatic logic [BHR_BITS-1:0] gshare_index(
    input logic [BHR_BITS-1:0] pc_bits,
    input logic [BHR_BITS-1:0] bhr
  );
    return pc_bits ^ bhr;
  endfunction

endpackage

// File: rtl/gshare_branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter step used on the PHT training path.
module gshare_branch_predictor_sat_counter2 (
  input  logic [1:0] count,
  input  logic       inc,
  output logic [1:0] next_count
);

  // Saturating increment on inc, saturating decrement otherwise
  always_comb begin
    next_count = count;
    if (inc) begin
      if (count != 2'b11) begin
        next_count = count + 2'b01;
      end else begin
        next_count = 2'b11;
      end
    end else begin
      if (count != 2'b00) begin
        next_count = count - 2'b01;
      end else begin
        next_count = 2'b00;
      end
    end
  end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Gshare predictor: 8-bit BHR, 256 x 2-bit PHT, 16-entry direct-mapped BTB.
// Optional BP_STATS_EN adds branch and mispredict counters.
module gshare_branch_predictor
  import gshare_branch_predictor_pkg::*;
(
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [FROM_FE_TO_PREDICTOR_WIDTH-1:0]   from_FE_to_predictor,
  output logic [FROM_PREDICTOR_TO_FE_WIDTH-1:0]   from_predictor_to_FE,
  input  logic [FROM_AGEX_TO_PREDICTOR_WIDTH-1:0] from_AGEX_to_predictor
`ifdef BP_STATS_EN
  ,
  output logic [31:0]                             stat_branches,
  output logic [31:0]                             stat_mispredicts
`endif
);

  logic [BHR_BITS-1:0] bhr_r;
  logic [1:0]          pht_r [PHT_ENTRIES];
  btb_entry_t          btb_r [BTB_ENTRIES];

  agex_upd_t           upd_s;
  fe_pred_t            pred_s;
  logic [31:0]         fe_pc_s;

  logic [BHR_BITS-1:0]     lk_bhr_s;
  logic [BHR_BITS-1:0]     lk_pht_idx_s;
  logic [BTB_IDX_BITS-1:0] lk_btb_idx_s;
  btb_entry_t              lk_entry_s;
  logic [1:0]              lk_cnt_s;
  logic                    lk_hit_s;

  logic [1:0]              upd_cnt_s;
  logic [1:0]              upd_cnt_next_s;
  logic [BTB_IDX_BITS-1:0] upd_btb_idx_s;
  logic                    unused_s;

  assign upd_s                = agex_upd_t'(from_AGEX_to_predictor);
  assign fe_pc_s              = from_FE_to_predictor;
  assign from_predictor_to_FE = pred_s;
  assign upd_btb_idx_s        = upd_s.upd_pc[5:2];
  assign upd_cnt_s            = pht_r[upd_s.upd_pht_index];
  assign unused_s             = ^{fe_pc_s[1:0], upd_s.upd_pc[1:0]};

  gshare_branch_predictor_sat_counter2 u_pht_upd (
    .count      (upd_cnt_s),
    .inc        (upd_s.upd_taken),
    .next_count (upd_cnt_next_s)
  );

  // Same-cycle lookup; while reset is high the outputs show the cleared state
  always_comb begin
    lk_btb_idx_s = fe_pc_s[5:2];
    lk_entry_s   = btb_r[lk_btb_idx_s];
    if (reset) begin
      lk_bhr_s     = '0;
      lk_pht_idx_s = gshare_index(fe_pc_s[9:2], 8'h00);
      lk_cnt_s     = PHT_INIT;
      lk_hit_s     = 1'b0;
    end else begin
      lk_bhr_s     = bhr_r;
      lk_pht_idx_s = gshare_index(fe_pc_s[9:2], bhr_r);
      lk_cnt_s     = pht_r[lk_pht_idx_s];
      lk_hit_s     = lk_entry_s.valid && (lk_entry_s.tag == fe_pc_s[31:6]);
    end

    pred_s.taken       = lk_hit_s && (!lk_entry_s.cond || lk_cnt_s[1]);
    pred_s.target_addr = lk_hit_s ? lk_entry_s.target : 32'h0000_0000;
    pred_s.bhr         = lk_bhr_s;
    pred_s.pht_index   = lk_pht_idx_s;
    pred_s.pht_entry   = lk_cnt_s;
    pred_s.btb_index   = lk_btb_idx_s;
  end

  // Training: PHT uses the index carried from fetch, never the current BHR
  always_ff @(posedge clk) begin
    if (reset) begin
      bhr_r <= '0;
      for (int i = 0; i < PHT_ENTRIES; i++) begin
        pht_r[i] <= PHT_INIT;
      end
      for (int j = 0; j < BTB_ENTRIES; j++) begin
        btb_r[j] <= '0;
      end
    end else if (upd_s.upd_valid) begin
      if (upd_s.upd_is_cond) begin
        pht_r[upd_s.upd_pht_index] <= upd_cnt_next_s;
        bhr_r <= {bhr_r[BHR_BITS-2:0], upd_s.upd_taken};
      end
      if (upd_s.upd_taken) begin
        btb_r[upd_btb_idx_s] <= '{valid:  1'b1,
                                  cond:   upd_s.upd_is_cond,
                                  tag:    upd_s.upd_pc[31:6],
                                  target: upd_s.upd_target};
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_branches_r;
  logic [31:0] stat_mispredicts_r;
  btb_entry_t  upd_entry_s;
  logic        upd_hit_s;
  logic        upd_pred_s;

  // Prediction the update would have received, from pre-update state
  always_comb begin
    upd_entry_s = btb_r[upd_btb_idx_s];
    upd_hit_s   = upd_entry_s.valid && (upd_entry_s.tag == upd_s.upd_pc[31:6]);
    if (upd_s.upd_is_cond) begin
      upd_pred_s = upd_cnt_s[1];
    end else begin
      upd_pred_s = upd_hit_s;
    end
  end

  // Free-running statistics, wrap at 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches_r    <= 32'd0;
      stat_mispredicts_r <= 32'd0;
    end else if (upd_s.upd_valid) begin
      stat_branches_r <= stat_branches_r + 32'd1;
      if (upd_s.upd_taken ^ upd_pred_s) begin
        stat_mispredicts_r <= stat_mispredicts_r + 32'd1;
      end
    end
  end

  assign stat_branches    = stat_branches_r;
  assign stat_mispredicts = stat_mispredicts_r;
`endif

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Table-driven bench for gshare_branch_predictor with an expected-value queue.
module tb_gshare_branch_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] fe;
  logic [54:0] pred;
  logic [74:0] agex;
`ifdef BP_STATS_EN
  logic [31:0] st_br;
  logic [31:0] st_mp;
`endif

  gshare_branch_predictor dut (
    .clk                    (clk),
    .reset                  (reset),
    .from_FE_to_predictor   (fe),
    .from_predictor_to_FE   (pred),
    .from_AGEX_to_predictor (agex)
`ifdef BP_STATS_EN
    ,
    .stat_branches          (st_br),
    .stat_mispredicts       (st_mp)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        uv, uc, ut;
    logic [31:0] upc, utgt;
    logic [7:0]  uidx;
    logic        et;
    logic [31:0] etg;
    logic [7:0]  eb, ei;
    logic [1:0]  ee;
    logic [3:0]  ebi;
  } vec_t;

  typedef struct {
    int          id;
    logic        et;
    logic [31:0] etg;
    logic [7:0]  eb, ei;
    logic [1:0]  ee;
    logic [3:0]  ebi;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic rst, input logic [31:0] pc,
                              input logic uv, input logic uc, input logic ut,
                              input logic [31:0] upc, input logic [31:0] utgt,
                              input logic [7:0] uidx, input logic et,
                              input logic [31:0] etg, input logic [7:0] eb,
                              input logic [7:0] ei, input logic [1:0] ee,
                              input logic [3:0] ebi);
    vec_t v;
    v.rst = rst; v.pc = pc; v.uv = uv; v.uc = uc; v.ut = ut;
    v.upc = upc; v.utgt = utgt; v.uidx = uidx;
    v.et = et; v.etg = etg; v.eb = eb; v.ei = ei; v.ee = ee; v.ebi = ebi;
    return v;
  endfunction

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=%h exp=%h", name, id, act, exp);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty got=0 exp=1");
    end else begin
      e = sb.pop_front();
      chk("taken",       e.id, {31'd0, pred[54]},    {31'd0, e.et});
      chk("target_addr", e.id, pred[53:22],          e.etg);
      chk("bhr",         e.id, {24'd0, pred[21:14]}, {24'd0, e.eb});
      chk("pht_index",   e.id, {24'd0, pred[13:6]},  {24'd0, e.ei});
      chk("pht_entry",   e.id, {30'd0, pred[5:4]},   {30'd0, e.ee});
      chk("btb_index",   e.id, {28'd0, pred[3:0]},   {28'd0, e.ebi});
    end
  endtask

  task automatic apply(input vec_t v, input int id);
    exp_t e;
    reset = v.rst;
    fe    = v.pc;
    agex  = {v.uv, v.uc, v.ut, v.upc, v.utgt, v.uidx};
    e.id = id; e.et = v.et; e.etg = v.etg; e.eb = v.eb;
    e.ei = v.ei; e.ee = v.ee; e.ebi = v.ebi;
    sb.push_back(e);
    @(negedge clk);
    compare_front();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    reset = 1'b1;
    fe    = 32'h0;
    agex  = '0;

    //            rst  pc            v    c    t    upc           utgt          uidx   | taken target        bhr    idx    ent    bidx
    vecs.push_back(mk(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   8'h00, 1'b0, 32'h0,   8'h00, 8'h40, 2'b01, 4'h0));
    vecs.push_back(mk(1'b0, 32'h100, 1'b1, 1'b1, 1'b1, 32'h100, 32'h200, 8'h40, 1'b0, 32'h0,   8'h00, 8'h40, 2'b01, 4'h0));
    vecs.push_back(mk(1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   8'h00, 1'b0, 32'h200, 8'h01, 8'h41, 2'b01, 4'h0));
    vecs.push_back(mk(1'b0, 32'h104, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   8'h00, 1'b0, 32'h0,   8'h01, 8'h40, 2'b10, 4'h1));
    // uncond taken at 0x140 with same-cycle lookup: old view, then new
    vecs.push_back(mk(1'b0, 32'h140, 1'b1, 1'b0, 1'b1, 32'h140, 32'h300, 8'h00, 1'b0, 32'h0,   8'h01, 8'h51, 2'b01, 4'h0));
    vecs.push_back(mk(1'b0, 32'h140, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   8'h00, 1'b1, 32'h300, 8'h01, 8'h51, 2'b01, 4'h0));
    vecs.push_back(mk(1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   8'h00, 1'b0, 32'h0,   8'h01, 8'h41, 2'b01, 4'h0));
    // counter at 0x10 trained up to saturation and back, observed each cycle
    vecs.push_back(mk(1'b0, 32'h044, 1'b1, 1'b1, 1'b1, 32'h180, 32'h280, 8'h10, 1'b0, 32'h0,   8'h01, 8'h10, 2'b01, 4'h1));
    vecs.push_back(mk(1'b0, 32'h04C, 1'b1, 1'b1, 1'b1, 32'h180, 32'h280, 8'h10, 1'b0, 32'h0,   8'h03, 8'h10, 2'b10, 4'h3));
    vecs.push_back(mk(1'b0, 32'h05C, 1'b1, 1'b1, 1'b1, 32'h180, 32'h280, 8'h10, 1'b0, 32'h0,   8'h07, 8'h10, 2'b11, 4'h7));
    vecs.push_back(mk(1'b0, 32'h07C, 1'b1, 1'b1, 1'b1, 32'h180, 32'h280, 8'h10, 1'b0, 32'h0,   8'h0F, 8'h10, 2'b11, 4'hF));
    vecs.push_back(mk(1'b0, 32'h03C, 1'b1, 1'b1, 1'b0, 32'h180, 32'h999, 8'h10, 1'b0, 32'h0,   8'h1F, 8'h10, 2'b11, 4'hF));
    vecs.push_back(mk(1'b0, 32'h0B8, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   8'h00, 1'b0, 32'h0,   8'h3E, 8'h10, 2'b10, 4'hE));
    vecs.push_back(mk(1'b0, 32'h180, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   8'h00, 1'b0, 32'h280, 8'h3E, 8'h5E, 2'b01, 4'h0));
    // alias at BTB index 0: 0x500 misses, then replaces 0x180
    vecs.push_back(mk(1'b0, 32'h500, 1'b1, 1'b0, 1'b1, 32'h500, 32'h600, 8'h00, 1'b0, 32'h0,   8'h3E, 8'h7E, 2'b01, 4'h0));
    vecs.push_back(mk(1'b0, 32'h500, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   8'h00, 1'b1, 32'h600, 8'h3E, 8'h7E, 2'b01, 4'h0));
    vecs.push_back(mk(1'b0, 32'h180, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   8'h00, 1'b0, 32'h0,   8'h3E, 8'h5E, 2'b01, 4'h0));
    // upd_valid=0 with busy fields must not change anything
    vecs.push_back(mk(1'b0, 32'h500, 1'b0, 1'b1, 1'b1, 32'h100, 32'h999, 8'h7E, 1'b1, 32'h600, 8'h3E, 8'h7E, 2'b01, 4'h0));
    vecs.push_back(mk(1'b0, 32'h500, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   8'h00, 1'b1, 32'h600, 8'h3E, 8'h7E, 2'b01, 4'h0));
    // reset mid-stream with a concurrent update that must be dropped
    vecs.push_back(mk(1'b1, 32'h500, 1'b1, 1'b1, 1'b1, 32'h500, 32'h700, 8'h7E, 1'b0, 32'h0,   8'h00, 8'h40, 2'b01, 4'h0));
    vecs.push_back(mk(1'b0, 32'h500, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   8'h00, 1'b0, 32'h0,   8'h00, 8'h40, 2'b01, 4'h0));
    vecs.push_back(mk(1'b0, 32'h040, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   8'h00, 1'b0, 32'h0,   8'h00, 8'h10, 2'b01, 4'h0));
    // decrement saturation at 00
    vecs.push_back(mk(1'b0, 32'h080, 1'b1, 1'b1, 1'b0, 32'h080, 32'h0,   8'h20, 1'b0, 32'h0,   8'h00, 8'h20, 2'b01, 4'h0));
    vecs.push_back(mk(1'b0, 32'h080, 1'b1, 1'b1, 1'b0, 32'h080, 32'h0,   8'h20, 1'b0, 32'h0,   8'h00, 8'h20, 2'b00, 4'h0));
    vecs.push_back(mk(1'b0, 32'h080, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   8'h00, 1'b0, 32'h0,   8'h00, 8'h20, 2'b00, 4'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // History shift: eight taken cond updates at pc 0 walk BHR from 00 to FF
    for (int k = 0; k <= 8; k++) begin
      logic [7:0] b;
      b = 8'((1 << k) - 1);
      v = mk(1'b0, 32'h0, (k < 8) ? 1'b1 : 1'b0, 1'b1, 1'b1, 32'h0, 32'h4, b,
             1'b0, (k == 0) ? 32'h0 : 32'h4, b, b, 2'b01, 4'h0);
      apply(v, 100 + k);
    end

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gshare_branch_predictor.md
Name: gshare_branch_predictor

Overview:
- Responder side of the fetch-stage prediction interface.
- Fetch sends its current PC each cycle. This block returns a same-cycle prediction: taken, target, and history/index snapshots that travel down the pipe with the instruction.
- Execute (AGEX) sends resolved branch outcomes back; this block uses them to train an 8-bit global history register, a 256-entry 2-bit counter PHT (gshare index) and a 16-entry direct-mapped BTB.
- Sits beside the fetch stage; all tables are flop-based.

Parameters:
- BHR_BITS, 8, global history length; also sets PHT index width.
- PHT_ENTRIES, 256, number of 2-bit counters (2^BHR_BITS).
- BTB_ENTRIES, 16, BTB depth, indexed by PC[5:2].
- PHT_INIT, 2'b01, counter reset value (weakly not-taken).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- from_FE_to_predictor  in  32  lookup PC (`from_FE_to_predictor_WIDTH`).
- from_predictor_to_FE  out  55  {taken, target_addr[31:0], BHR[7:0], PHT_index[7:0], PHT_entry[1:0], BTB_index[3:0]} (`from_predictor_to_FE_WIDTH`).
- from_AGEX_to_predictor  in  75  {upd_valid, upd_is_cond, upd_taken, upd_pc[31:0], upd_target[31:0], upd_pht_index[7:0]} (`from_AGEX_to_predictor_WIDTH`).

Behaviour:
- Lookup path is purely combinational from the lookup PC and current state; zero-cycle latency.
- Index and tag fields:
  - PHT_index = PC[9:2] XOR BHR.
  - BTB_index = PC[5:2].
  - BTB tag = PC[31:6].
- BTB entry fields: valid, cond, tag[25:0], target[31:0] (60 bits).
- btb_hit = entry.valid AND entry.tag == PC[31:6].
- taken = btb_hit AND (NOT entry.cond OR PHT[PHT_index][1]).
- target_addr = btb_hit ? entry.target : 32'h0.
- BHR, PHT_index and PHT_entry outputs are current values, not gated by hit.
- Updates take effect at posedge when upd_valid=1:
  - upd_is_cond=1: PHT[upd_pht_index] saturating increment if upd_taken, else saturating decrement (11 stays 11 on taken; 00 stays 00 on not-taken). BHR <= {BHR[6:0], upd_taken}.
  - upd_is_cond=0: PHT and BHR untouched.
  - upd_taken=1 (cond or uncond): BTB[upd_pc[5:2]] <= {1, upd_is_cond, upd_pc[31:6], upd_target}, overwriting any alias.
  - upd_taken=0: BTB untouched; existing entries are never invalidated by not-taken outcomes.
- upd_valid=0: no state changes.
- The PHT update uses upd_pht_index, the index carried from fetch; it is never recomputed from the current BHR.
- BHR is updated only at resolution (non-speculative); no recovery logic is needed.
- Same-cycle lookup and update to the same entry: lookup returns the pre-update value; the new value is visible the following cycle. No bypass.
- Reset (any cycle, including mid-training):
  - BHR <= 0.
  - All PHT <= PHT_INIT.
  - All BTB valid <= 0.
  - An update presented during reset is dropped.
- Outputs during and right after reset: taken=0, target_addr=0, BHR=0, PHT_entry=01.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined: adds outputs stat_branches[31:0] and stat_mispredicts[31:0], both reset to 0.
  - stat_branches increments on each upd_valid.
  - stat_mispredicts increments when upd_valid AND (upd_taken XOR predicted), where predicted = upd_is_cond ? counter[1] at upd_pht_index before update : BTB hit for upd_pc before update.
  - Both counters wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared define.vh holds the three bus-width macros, BHR_BITS, and the PHT_INIT constant.
- Define the BTB entry field layout there too, for AGEX/DE unpacking.
- One natural sub-module: sat_counter2 (2-bit saturating inc/dec), instantiated per PHT update path.

Test Plan:
- Reset, lookup PC=0x100 -> taken=0, target_addr=0, BHR=0, PHT_index=0x40, PHT_entry=01, BTB_index=0.
- Update {valid, cond, taken, pc=0x100, tgt=0x200, idx=0x40} -> next cycle BHR=0x01, PHT[0x40]=10. Lookup 0x100 -> PHT_index=0x41, PHT_entry=01, taken=0 despite BTB hit.
- Uncond update pc=0x140, tgt=0x300 -> BHR unchanged. Lookup 0x140 -> taken=1, target_addr=0x300.
- Four taken cond updates idx=0x10 -> 10, 11, 11, 11; then one not-taken -> 10. Counter[1] stays 1 throughout the last three states.
- After BTB fill at pc=0x100, lookup pc=0x500 (same index 0, tag mismatch) -> taken=0, target_addr=0. Update pc=0x500 taken -> lookup 0x100 now misses.
- Same-cycle update and lookup of 0x140 -> old outputs that cycle, new the next. Assert reset mid-stream -> all tables cleared next cycle and the concurrent update is ignored.
